dadda_final_cpa: RTL and testbench



---
 rtl/dadda_final_cpa.sv | 131 +++++++++++++
 tb/tb_dadda_final_cpa.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_final_cpa.sv
// Purpose : segmented, pipelined carry-propagate adder for the two 31-bit rows
//           left by the final Dadda reduction stage of the 16x16 multiplier.
// Latency : NUM_SEG edges counting the accept edge (4 for SEG_W=8).
// Backpr. : whole pipe holds while out_valid && !out_ready; in_ready drops.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   row0, row1          31-bit operand rows (bit i has weight 2^i)
//   in_valid/in_ready   input handshake (in_ready independent of in_valid)
//   product             32-bit sum of the rows, bit 31 is the final carry
//   out_valid/out_ready output handshake, product registered
//   done_cnt            count of delivered products, wraps silently
module dadda_final_cpa #(
  parameter int SEG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [30:0]      row0,
  input  logic [30:0]      row1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int NUM_SEG = 32 / SEG_W;

  if (SEG_W != 4 && SEG_W != 8 && SEG_W != 16 && SEG_W != 32) begin : g_bad_seg_w
    $error("dadda_final_cpa: SEG_W must be 4, 8, 16 or 32");
  end

  // Stage registers; index k holds the state of stage s(k+1).
  logic [31:0]      r_a   [NUM_SEG];
  logic [31:0]      r_b   [NUM_SEG];
  logic [31:0]      r_sum [NUM_SEG];
  logic             r_cy  [NUM_SEG];
  logic             r_vld [NUM_SEG];
  logic [CNT_W-1:0] r_done_cnt;

  // Next-state values for each stage.
  logic [31:0]      w_nxt_a   [NUM_SEG];
  logic [31:0]      w_nxt_b   [NUM_SEG];
  logic [31:0]      w_nxt_sum [NUM_SEG];
  logic             w_nxt_cy  [NUM_SEG];
  logic             w_nxt_vld [NUM_SEG];

  logic w_adv;
  logic w_unused_tail;

  assign out_valid = r_vld[NUM_SEG-1];
  assign product   = r_sum[NUM_SEG-1];
  assign done_cnt  = r_done_cnt;

  // The pipe moves as a whole; bubbles travel with it.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // The output stage's leftover operands and carry are never consumed:
  // the sum of two 31-bit rows cannot carry out of bit 31.
  assign w_unused_tail = ^{r_a[NUM_SEG-1], r_b[NUM_SEG-1], r_cy[NUM_SEG-1]};

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    logic [31:0]    w_a;
    logic [31:0]    w_b;
    logic [31:0]    w_s;
    logic [31:0]    w_ns;
    logic           w_c;
    logic           w_v;
    logic [SEG_W:0] w_seg;

    // Segment k is resolved on the way into stage k (s(k+1)).
    if (k == 0) begin : g_first
      assign w_a = {1'b0, row0};
      assign w_b = {1'b0, row1};
      assign w_s = '0;
      assign w_c = 1'b0;
      assign w_v = in_valid;
    end else begin : g_rest
      assign w_a = r_a[k-1];
      assign w_b = r_b[k-1];
      assign w_s = r_sum[k-1];
      assign w_c = r_cy[k-1];
      assign w_v = r_vld[k-1];
    end

    assign w_seg = {1'b0, w_a[k*SEG_W +: SEG_W]}
                 + {1'b0, w_b[k*SEG_W +: SEG_W]}
                 + {{SEG_W{1'b0}}, w_c};

    always_comb begin
      w_ns = w_s;
      w_ns[k*SEG_W +: SEG_W] = w_seg[SEG_W-1:0];
    end

    assign w_nxt_a[k]   = w_a;
    assign w_nxt_b[k]   = w_b;
    assign w_nxt_sum[k] = w_ns;
    assign w_nxt_cy[k]  = w_seg[SEG_W];
    assign w_nxt_vld[k] = w_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SEG; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_cy[k]  <= 1'b0;
        r_vld[k] <= 1'b0;
      end
      r_done_cnt <= '0;
    end else begin
      if (w_adv) begin
        for (int k = 0; k < NUM_SEG; k++) begin
          r_a[k]   <= w_nxt_a[k];
          r_b[k]   <= w_nxt_b[k];
          r_sum[k] <= w_nxt_sum[k];
          r_cy[k]  <= w_nxt_cy[k];
          r_vld[k] <= w_nxt_vld[k];
        end
      end
      if (out_valid && out_ready) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dadda_final_cpa.sv
module tb_dadda_final_cpa;

  localparam int SEG_W   = 8;
  localparam int CNT_W   = 16;
  localparam int LATENCY = 32 / SEG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [30:0]      row0;
  logic [30:0]      row1;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      product;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      exp_q[$];
  logic [31:0]      cur_exp;
  logic [CNT_W-1:0] n_done;

  always #5 clk = ~clk;

  dadda_final_cpa #(.SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .row0(row0), .row1(row1),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .done_cnt(done_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the sum of the two rows as plain integers.
  task automatic drive(input logic [30:0] r0, input logic [30:0] r1);
    row0    = r0;
    row1    = r1;
    cur_exp = {1'b0, r0} + {1'b0, r1};
  endtask

  // Reference: a*b, with the product split into two arbitrary 31-bit rows.
  task automatic drive_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p       = {16'd0, a} * {16'd0, b};
    row0    = p[31:1];
    row1    = 31'(p - {1'b0, p[31:1]});
    cur_exp = p;
  endtask

  // One clock: observe handshakes before the edge, update the model, check after.
  task automatic tick();
    logic acc;
    logic del;
    logic [31:0] e;
    @(negedge clk);
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (!rst) begin
      if (del) begin
        chk("deliver_has_expected", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("product", product, e);
        end
        n_done = n_done + CNT_W'(1);
      end
      if (acc) exp_q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      n_done = '0;
    end
    chk("done_cnt", done_cnt, n_done);
  endtask

  task automatic drain();
    int g;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 64) begin
      tick();
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] vals [6];
    vals = '{16'd0, 16'd5, 16'd1024, 16'd3024, 16'd19283, 16'd65535};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n_done = '0;
    drive(31'd0, 31'd0);

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_product", product, 32'd0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Carry ripple through every segment, latency measurement
    out_ready = 1'b1;
    drive(31'h7FFF_FFFF, 31'h0000_0001);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("ripple_in_ready", in_ready, 1'b1);
      tick();
      lat++;
    end
    chk("ripple_latency", lat, LATENCY);
    chk("ripple_product", product, 32'h8000_0000);
    drain();

    // Max sum then back-to-back stream
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(31'h7FFF_FFFF, 31'h7FFF_FFFF); tick();
    drive(31'd0, 31'd0);                 tick();
    drive(31'd15120, 31'd0);             tick();
    drive(31'd1, 31'd2);                 tick();
    in_valid = 1'b0;
    chk("max_sum_product", product, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_consecutive", out_valid, 1'b1);
    end
    chk("stream_last_product", product, 32'd3);
    tick();
    chk("stream_idle", out_valid, 1'b0);
    chk("stream_done_cnt", done_cnt, 4);

    // Multiplier end to end and operand sweep
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_mul(16'd52968, 16'd62468);
    chk("mul_ref_known", cur_exp, 32'd3308805024);
    tick();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        drive_mul(vals[i], vals[j]);
        tick();
      end
    end
    drain();

    // Backpressure: fill, hold, release
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(31'($urandom), 31'($urandom));
      tick();
    end
    chk("bp_first_valid", out_valid, 1'b1);
    chk("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(31'($urandom), 31'($urandom));
      tick();
      chk("bp_hold_product", product, exp_q[0]);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_all_delivered", exp_q.size(), 0);
    chk("bp_done_cnt", done_cnt, 4);
    chk("bp_idle", out_valid, 1'b0);

    // Reset with three transactions in flight
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(31'($urandom), 31'($urandom));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_done_cnt", done_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < LATENCY + 2; i++) begin
      tick();
      chk("no_stale_result", out_valid, 1'b0);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 7) == 0) ? 31'h7FFF_FFFF : 31'($urandom),
            ($urandom_range(0, 7) == 0) ? 31'h7FFF_FFFF : 31'($urandom));
      tick();
    end
    drain();
    chk("final_idle", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
